fifo_ctrl: RTL
==============

FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter AF_THRESH, default 56, almost_full asserts when count >= AF_THRESH.
REQ-002 Parameter AE_THRESH, default 8, almost_empty asserts when count <= AE_THRESH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 push  input  1  write request from upstream.
REQ-006 data_in  input  8  write data accompanying push.
REQ-007 pop  input  1  read request from downstream.
REQ-008 data_out  output  8  read data, direct from q_b.
REQ-009 valid_out  output  1  data_out holds popped word this cycle.
REQ-010 full, empty, almost_full, almost_empty  output  1 each  occupancy flags.
REQ-011 err  output  1  sticky overflow/underflow flag.
REQ-012 addr_a  output  6  RAM port A write address.
REQ-013 data_a  output  8  RAM port A write data.
REQ-014 we_a  output  1  RAM port A write enable.
REQ-015 addr_b  output  6  RAM port B read address.
REQ-016 data_b  output  8  RAM port B data, constant 0.
REQ-017 we_b  output  1  RAM port B write enable, constant 0.
REQ-018 q_b  input  8  RAM port B read data; valid one clk after addr_b.

Function
REQ-019 Depth 64 words; 6-bit wr_ptr, rd_ptr, 7-bit count (0..64).
REQ-020 push accepted iff push && !full; pop accepted iff pop && !empty; no bypass in either direction.
REQ-021 Accepted push: we_a=1, addr_a=wr_ptr, data_a=data_in combinationally; wr_ptr increments at edge, 63 wraps to 0.
REQ-022 addr_b=rd_ptr at all times; accepted pop increments rd_ptr at edge, 63 wraps to 0.
REQ-023 valid_out registered: high the cycle after an accepted pop, low otherwise; data_out=q_b.
REQ-024 count: +1 push only, -1 pop only, unchanged for both or neither.
REQ-025 Registered FSM states EMPTY (count 0), MID (1..63), FULL (64); next state from next count; empty=EMPTY, full=FULL.
REQ-026 Push while full: rejected, state unchanged; pop while empty: rejected, valid_out stays 0.
REQ-027 Push+pop while full: pop accepted, push rejected, next state MID, count 63.
REQ-028 Push+pop while empty: push accepted, pop rejected, next state MID, count 1.
REQ-029 almost_full/almost_empty registered from next count, same cycle as count update.

Reset
REQ-030 reset_L low at any time: pointers 0, count 0, state EMPTY, valid_out 0, err 0, empty 1, almost_empty 1, full 0, almost_full 0; in-flight pop discarded.
REQ-031 During reset we_a=0 and no pointer moves; normal operation from first edge with reset_L high.

Configuration
REQ-032 Macro FIFO_CTRL_ERR_EN defined: err set by rejected push (overflow) or rejected pop (underflow), held until reset.
REQ-033 Macro FIFO_CTRL_ERR_EN undefined: err tied 0, no error logic; port remains.

Structure
REQ-034 Package fifo_pkg: DATA_W=8, ADDR_W=6, DEPTH=64, FSM state encoding.
REQ-035 Sub-module fifo_ptr (wrapping 6-bit pointer with increment enable), instantiated for write and read.

Verification
REQ-036 Reset, push 0x11,0x22,0x33 -> addr_a 0,1,2 with we_a=1; count 3; empty 0; almost_empty 1.
REQ-037 Three pops after REQ-036 -> valid_out pulses; data_out 0x11,0x22,0x33 one cycle after each pop; empty 1.
REQ-038 Push 64 words -> full 1 at count 64, almost_full 1 from count 56; 65th push: we_a=0, err 1 (macro on).
REQ-039 When full, push+pop same cycle -> count 63, full 0, oldest word returned, incoming word dropped.
REQ-040 Fill/drain 100 words across wrap -> order preserved; pointers wrap 63->0; no err.
REQ-041 reset_L low mid-traffic (count 20) -> all outputs at reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared widths, depth and occupancy-state encoding for the 64-word FIFO controller.
package fifo_pkg;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 6;
   localparam int DEPTH  = 64;
   localparam int CNT_W  = 7;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_MID   = 2'd1,
      ST_FULL  = 2'd2
   } fifo_state_t;

   function automatic fifo_state_t state_of(input logic [CNT_W-1:0] cnt);
      if (cnt == '0)
         return ST_EMPTY;
      else if (cnt == CNT_W'(DEPTH))
         return ST_FULL;
      return ST_MID;
   endfunction
endpackage

// File: rtl/fifo_ptr.sv
// Wrapping RAM address pointer; advances by one when inc is high, 63 rolls to 0.
module fifo_ptr
   import fifo_pkg::*;
(
   input  logic              clk,
   input  logic              reset_L,
   input  logic              inc,
   output logic [ADDR_W-1:0] ptr
);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)
         ptr <= '0;
      else if (inc)
         ptr <= ptr + ADDR_W'(1);
   end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller driving an external dual-port RAM (port A write, port B read).
// Optional sticky overflow/underflow flag enabled with macro FIFO_CTRL_ERR_EN.
//
//   state    | meaning
//   ST_EMPTY | count == 0, pops rejected
//   ST_MID   | 1 <= count <= 63
//   ST_FULL  | count == 64, pushes rejected
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int AF_THRESH = 56,
   parameter int AE_THRESH = 8
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic              push,
   input  logic [DATA_W-1:0] data_in,
   input  logic              pop,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              err,
   output logic [ADDR_W-1:0] addr_a,
   output logic [DATA_W-1:0] data_a,
   output logic              we_a,
   output logic [ADDR_W-1:0] addr_b,
   output logic [DATA_W-1:0] data_b,
   output logic              we_b,
   input  logic [DATA_W-1:0] q_b
);

   localparam logic [CNT_W-1:0] AF_T = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] AE_T = CNT_W'(AE_THRESH);

   fifo_state_t       state;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_nxt;
   logic              wr_en;
   logic              rd_en;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;

   assign full  = (state == ST_FULL);
   assign empty = (state == ST_EMPTY);

   assign wr_en = push && !full;
   assign rd_en = pop && !empty;

   // reset_L gating keeps the RAM from being written while the controller is held in reset
   assign we_a     = wr_en && reset_L;
   assign addr_a   = wr_ptr;
   assign data_a   = data_in;
   assign addr_b   = rd_ptr;
   assign data_b   = '0;
   assign we_b     = 1'b0;
   assign data_out = q_b;

   fifo_ptr u_wr_ptr (
      .clk     (clk),
      .reset_L (reset_L),
      .inc     (wr_en),
      .ptr     (wr_ptr)
   );

   fifo_ptr u_rd_ptr (
      .clk     (clk),
      .reset_L (reset_L),
      .inc     (rd_en),
      .ptr     (rd_ptr)
   );

   always_comb begin
      count_nxt = count;
      if (wr_en && !rd_en)
         count_nxt = count + CNT_W'(1);
      else if (rd_en && !wr_en)
         count_nxt = count - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state        <= ST_EMPTY;
         count        <= '0;
         valid_out    <= 1'b0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
      end else begin
         state        <= state_of(count_nxt);
         count        <= count_nxt;
         valid_out    <= rd_en;
         almost_full  <= (count_nxt >= AF_T);
         almost_empty <= (count_nxt <= AE_T);
      end
   end

`ifdef FIFO_CTRL_ERR_EN
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)
         err <= 1'b0;
      else if ((push && full) || (pop && empty))
         err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

endmodule
